adc_sample_fifo: RTL and testbench

Parametrised single-clock sample FIFO between the ADC capture front end and the host read interface. It generalises the existing 16-bit read FIFO to configurable width and depth, and adds:
- a synchronous, registered read handshake instead of a read-strobe clock and tri-state output;
- full, almost-full and level reporting;
- sticky overflow/underflow flags;
- synchronous flush.

---
 rtl/adc_fifo_pkg.sv | 12 +
 rtl/adc_fifo_ram.sv | 52 +++++
 rtl/adc_sample_fifo.sv | 124 ++++++++++++
 tb/tb_adc_sample_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_fifo_pkg.sv
// Shared defaults and sizing helpers for the ADC sample FIFO.
package adc_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 9;

  // Bits needed to count 0..2**addr_width inclusive (one more than the pointer width).
  function automatic int level_width(input int addr_width);
    return $clog2((1 << addr_width) + 1);
  endfunction

endpackage

// File: rtl/adc_fifo_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The array itself has no reset so it maps onto block RAM; only the output
// register is reset so the read data starts from a known value.
module adc_fifo_ram
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Write port: store the sample on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data only changes on an accepted read, otherwise it holds the last word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Registered read output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_sample_fifo.sv
// Single-clock sample FIFO between ADC capture and the host read interface.
// Occupancy is tracked in a dedicated counter one bit wider than the pointers
// so full and empty are never ambiguous. All status is derived from registers.
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  d_valid,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] wr_faddr,
  output logic [ADDR_WIDTH-1:0] rd_faddr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_flags
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = level_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ok, rd_ok;

  assign empty       = (level_q == '0);
  assign full        = (level_q == LW'(DEPTH));
  assign almost_full = (level_q >= LW'(AFULL_LEVEL));

  // Accept decisions use the pre-cycle status; flush suppresses both sides.
  assign wr_ok = d_valid & ~full  & ~flush;
  assign rd_ok = rd      & ~empty & ~flush;

  // Next-state for pointers, level, sticky flags and the read-valid pulse.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = rd_ok;

    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (clr_flags) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (d_valid && full)  overflow_d  = 1'b1;
    if (rd && empty)      underflow_d = 1'b1;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      rd_valid_d  = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  adc_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_i),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (data_o)
  );

  assign rd_valid  = rd_valid_q;
  assign wr_faddr  = wr_ptr_q;
  assign rd_faddr  = rd_ptr_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Scoreboard bench for adc_sample_fifo using a small 16-entry configuration.
module tb_adc_sample_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          d_valid;
  logic [DW-1:0] data_i;
  logic          rd;
  logic [DW-1:0] data_o;
  logic          rd_valid;
  logic [AW-1:0] wr_faddr;
  logic [AW-1:0] rd_faddr;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic          underflow;
  logic          clr_flags;

  int compared   = 0;
  int mismatched = 0;
  logic [DW-1:0] exp_q [$];

  adc_sample_fifo #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .d_valid     (d_valid),
    .data_i      (data_i),
    .rd          (rd),
    .data_o      (data_o),
    .rd_valid    (rd_valid),
    .wr_faddr    (wr_faddr),
    .rd_faddr    (rd_faddr),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_flags   (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Advance one clock; inputs change and status is checked 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_rd_valid: got data %0h, expected no read", data_o);
      end else begin
        check("read_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [AW-1:0] rp_saved;
    bit saw_wr_zero;
    bit saw_rd_zero;

    reset = 1'b0; flush = 1'b0; d_valid = 1'b0; data_i = '0; rd = 1'b0; clr_flags = 1'b0;
    #23;
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_data_o", 32'(data_o), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_flags", {30'd0, overflow, underflow}, 0);
    check("rst_ptrs", {wr_faddr, rd_faddr}, 0);
    tick();
    reset = 1'b1;
    tick();

    // Three writes then three back-to-back reads.
    for (int i = 1; i <= 3; i++) begin
      d_valid = 1'b1; data_i = DW'(i);
      tick();
      check("t1_wr_level", 32'(level), 32'(i));
    end
    d_valid = 1'b0; rd = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(DW'(i));
      tick();
      check("t1_rd_level", 32'(level), 32'(3 - i));
    end
    rd = 1'b0;
    check("t1_empty", 32'(empty), 1);
    tick();

    // Fill to full, observe almost_full threshold, then overflow and drain.
    for (int i = 0; i < DEPTH; i++) begin
      d_valid = 1'b1; data_i = DW'(i);
      tick();
      check("t2_level", 32'(level), 32'(i + 1));
      check("t2_afull", 32'(almost_full), (i + 1 >= AFULL) ? 32'd1 : 32'd0);
    end
    check("t2_full", 32'(full), 1);
    data_i = 16'hDEAD;
    tick();
    d_valid = 1'b0;
    check("t2_overflow", 32'(overflow), 1);
    check("t2_level_hold", 32'(level), DEPTH);
    rd = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(DW'(i));
      tick();
    end
    rd = 1'b0;
    tick();
    check("t2_drained", 32'(empty), 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 0);

    // Read while empty.
    rp_saved = rd_faddr;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("t3_rd_valid", 32'(rd_valid), 0);
    check("t3_underflow", 32'(underflow), 1);
    check("t3_rd_ptr", 32'(rd_faddr), 32'(rp_saved));
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t3_udf_clr", 32'(underflow), 0);

    // Sustained simultaneous traffic at level 4 across several pointer wraps.
    for (int i = 0; i < 4; i++) begin
      d_valid = 1'b1; data_i = DW'(100 + i);
      tick();
    end
    saw_wr_zero = 1'b0; saw_rd_zero = 1'b0;
    rd = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      data_i = DW'(104 + i);
      exp_q.push_back(DW'(100 + i));
      tick();
      if (level != 5'd4) check("t4_level", 32'(level), 4);
      if (wr_faddr == '0) saw_wr_zero = 1'b1;
      if (rd_faddr == '0) saw_rd_zero = 1'b1;
    end
    check("t4_level_end", 32'(level), 4);
    check("t4_ptr_wrap", {30'd0, saw_wr_zero, saw_rd_zero}, 3);
    d_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(DW'(148 + i));
      tick();
    end
    rd = 1'b0;
    check("t4_empty", 32'(empty), 1);

    // Simultaneous read and write at full: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) begin
      d_valid = 1'b1; data_i = DW'(16'h200 + i);
      tick();
    end
    rd = 1'b1; data_i = 16'h0BAD;
    exp_q.push_back(16'h200);
    tick();
    d_valid = 1'b0; rd = 1'b0;
    check("t5_full_ovf", 32'(overflow), 1);
    check("t5_full_level", 32'(level), DEPTH - 1);
    rd = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      exp_q.push_back(DW'(16'h200 + i));
      tick();
    end
    rd = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    // Simultaneous read and write at empty: write wins, read rejected.
    rd = 1'b1; d_valid = 1'b1; data_i = 16'h0300;
    tick();
    rd = 1'b0; d_valid = 1'b0;
    check("t5_empty_udf", 32'(underflow), 1);
    check("t5_empty_level", 32'(level), 1);
    check("t5_empty_rdv", 32'(rd_valid), 0);
    rd = 1'b1;
    exp_q.push_back(16'h0300);
    tick();
    rd = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Flush with rd, d_valid pending and a sticky flag set.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_valid = 1'b1; data_i = DW'(16'h400 + i);
      tick();
    end
    flush = 1'b1; rd = 1'b1; data_i = 16'h0499;
    tick();
    flush = 1'b0; rd = 1'b0; d_valid = 1'b0;
    check("t6_level", 32'(level), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_flags", {30'd0, overflow, underflow}, 0);
    check("t6_rd_valid", 32'(rd_valid), 0);
    check("t6_ptrs", {wr_faddr, rd_faddr}, 0);
    check("t6_data_hold", 32'(data_o), 32'h0300);
    tick();

    // Reset asserted in the middle of a write burst.
    for (int i = 0; i < 5; i++) begin
      d_valid = 1'b1; data_i = DW'(16'h500 + i);
      tick();
    end
    reset = 1'b0;
    #1;
    check("t7_level", 32'(level), 0);
    check("t7_empty", 32'(empty), 1);
    check("t7_data_o", 32'(data_o), 0);
    check("t7_wr_ptr", 32'(wr_faddr), 0);
    d_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    d_valid = 1'b1; data_i = 16'h0555;
    tick();
    d_valid = 1'b0;
    check("t7_post_wr_ptr", 32'(wr_faddr), 1);
    rd = 1'b1;
    exp_q.push_back(16'h0555);
    tick();
    rd = 1'b0;
    tick();
    tick();
    check("pending_reads", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
